// File: rtl/wb_dma_per_hs_if.sv
// ---------------------------------------------------------------------------
// wb_dma_per_hs_if
//
// Bundle of the per-channel peripheral-side and DMA-side handshake signals
// for wb_dma_per_hs. Every vector is ch_count wide, and bit i belongs to
// channel i.
//
//   Peripheral side : ch_en, per_avail, per_eop, per_abort, err_clr (to block)
//                     per_done, per_err                            (from block)
//   DMA side        : dma_ack_i                                    (to block)
//                     dma_req_o, dma_nd_o, dma_rest_o              (from block)
//   Debug           : state_dbg, 2 bits per channel (0=IDLE, 1=REQ, 2=GAP)
//
// Handshake: dma_req_o[i] is a level. Once it rises, it stays high until the
// first cycle where dma_ack_i[i] is sampled high, or until an abort, a drop
// of ch_en, or a timeout withdraws it. A transfer completes only on a cycle
// where req and ack are both high. When ack is sampled without req, it is
// ignored.
//
// Modports: slave = the handshake block, master = whatever drives it.
// ---------------------------------------------------------------------------
interface wb_dma_per_hs_if #(
    parameter int ch_count = 31
);
    logic [ch_count-1:0]   ch_en;
    logic [ch_count-1:0]   per_avail;
    logic [ch_count-1:0]   per_eop;
    logic [ch_count-1:0]   per_abort;
    logic [ch_count-1:0]   err_clr;
    logic [ch_count-1:0]   dma_ack_i;
    logic [ch_count-1:0]   per_done;
    logic [ch_count-1:0]   per_err;
    logic [ch_count-1:0]   dma_req_o;
    logic [ch_count-1:0]   dma_nd_o;
    logic [ch_count-1:0]   dma_rest_o;
    logic [2*ch_count-1:0] state_dbg;

    modport slave (
        input  ch_en, per_avail, per_eop, per_abort, err_clr, dma_ack_i,
        output per_done, per_err, dma_req_o, dma_nd_o, dma_rest_o, state_dbg
    );

    modport master (
        output ch_en, per_avail, per_eop, per_abort, err_clr, dma_ack_i,
        input  per_done, per_err, dma_req_o, dma_nd_o, dma_rest_o, state_dbg
    );
endinterface

// File: rtl/wb_dma_per_hs.sv
// ---------------------------------------------------------------------------
// wb_dma_per_hs
//
// Peripheral handshake front-end for the wb_dma channel request inputs.
// Each channel runs its own IDLE -> REQ -> GAP state machine. The machine
// turns the peripheral "chunk ready" level into a DMA request. It reports
// completion back as a per_done pulse and raises dma_nd_o when the chunk
// ends a packet. An abort, a drop of ch_en or a timeout withdraws the
// request with a dma_rest_o pulse.
//
// Ports:
//   clk    rising-edge clock
//   rst_i  synchronous, active-high reset
//   bus    wb_dma_per_hs_if.slave (see the interface for the signal list)
//
// Every output is registered.
// ---------------------------------------------------------------------------
module wb_dma_per_hs #(
    parameter int ch_count = 31,
    parameter int GAP_CYC  = 2,
    parameter int TMO_CYC  = 1024,
    parameter int TMO_W    = 16
) (
    input  logic               clk,
    input  logic               rst_i,
    wb_dma_per_hs_if.slave     bus
);

    localparam int GAP_EFF = (GAP_CYC < 1) ? 1 : GAP_CYC;
    // Wide enough to hold GAP_EFF-1.
    localparam int GAP_W = (GAP_EFF < 3) ? 1 : $clog2(GAP_EFF);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_EFF - 1);
    localparam bit TMO_ON = (TMO_CYC != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO_CYC == 0) ? 0 : TMO_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    for (genvar i = 0; i < ch_count; i++) begin : g_ch
        state_t           state_q;
        logic             eop_q;
        logic [GAP_W-1:0] gap_q;
        logic [TMO_W-1:0] tmo_q;
        logic             req_q;
        logic             done_q;
        logic             nd_q;
        logic             rest_q;
        logic             err_q;

        logic ack;
        logic abort_evt;
        logic tmo_hit;
        logic leave_req;
        logic err_set;

        assign ack       = bus.dma_ack_i[i];
        // Losing ch_en while requesting is handled exactly like an abort.
        assign abort_evt = bus.per_abort[i] | ~bus.ch_en[i];
        assign tmo_hit   = TMO_ON && (tmo_q == TMO_LAST);
        assign leave_req = ack | abort_evt | tmo_hit;
        // A timeout counts only when nothing else ends the request that cycle.
        assign err_set   = (state_q == REQ) & ~ack & ~abort_evt & tmo_hit;

        always_ff @(posedge clk) begin
            if (rst_i) begin
                state_q <= IDLE;
                eop_q   <= 1'b0;
                gap_q   <= '0;
                tmo_q   <= '0;
                req_q   <= 1'b0;
                done_q  <= 1'b0;
                nd_q    <= 1'b0;
                rest_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                done_q <= 1'b0;
                nd_q   <= 1'b0;
                rest_q <= 1'b0;
                // A set wins over a clear in the same cycle.
                err_q  <= err_set | (err_q & ~bus.err_clr[i]);

                case (state_q)
                    IDLE: begin
                        if (bus.ch_en[i] & bus.per_avail[i] & ~bus.per_abort[i]) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            eop_q   <= bus.per_eop[i];
                            tmo_q   <= '0;
                        end
                    end

                    REQ: begin
                        tmo_q <= tmo_q + 1'b1;
                        if (leave_req) begin
                            req_q <= 1'b0;
                            // Request stays low for GAP_EFF cycles in total.
                            // The IDLE cycle that samples per_avail again is
                            // one of them, so GAP itself lasts GAP_EFF-1 cycles
                            // and is skipped when that is zero.
                            if (GAP_EFF == 1) begin
                                state_q <= IDLE;
                            end else begin
                                state_q <= GAP;
                                gap_q   <= GAP_LOAD;
                            end
                        end
                        if (ack) begin
                            done_q <= 1'b1;
                            nd_q   <= eop_q & ~abort_evt;
                            rest_q <= abort_evt;
                        end else if (abort_evt | tmo_hit) begin
                            rest_q <= 1'b1;
                        end
                    end

                    GAP: begin
                        gap_q <= gap_q - 1'b1;
                        if (gap_q == GAP_W'(1)) begin
                            state_q <= IDLE;
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                endcase
            end
        end

        assign bus.dma_req_o[i]          = req_q;
        assign bus.per_done[i]           = done_q;
        assign bus.dma_nd_o[i]           = nd_q;
        assign bus.dma_rest_o[i]         = rest_q;
        assign bus.per_err[i]            = err_q;
        assign bus.state_dbg[2*i +: 2]   = state_q;
    end

endmodule

// File: tb/tb_wb_dma_per_hs.sv
// ---------------------------------------------------------------------------
// tb_wb_dma_per_hs
//
// Directed bench for wb_dma_per_hs with GAP_CYC=2 and TMO_CYC=8.
// Inputs change and outputs are observed on the falling edge. The DUT acts
// on the rising edge.
// ---------------------------------------------------------------------------
module tb_wb_dma_per_hs;

    localparam int N = 31;
    localparam logic [N-1:0] ALL = {N{1'b1}};
    localparam logic [N-1:0] NONE = '0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    wb_dma_per_hs_if #(.ch_count(N)) bus ();

    wb_dma_per_hs #(
        .ch_count(N),
        .GAP_CYC (2),
        .TMO_CYC (8),
        .TMO_W   (16)
    ) dut (
        .clk  (clk),
        .rst_i(rst_i),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];

    function automatic logic [N-1:0] bitv(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic zero_inputs();
        bus.ch_en     = '0;
        bus.per_avail = '0;
        bus.per_eop   = '0;
        bus.per_abort = '0;
        bus.err_clr   = '0;
        bus.dma_ack_i = '0;
    endtask

    // End any outstanding request with an ack and let every channel settle.
    task automatic drain();
        bus.per_avail = '0;
        bus.per_eop   = '0;
        bus.per_abort = '0;
        bus.dma_ack_i = ALL;
        tick();
        bus.dma_ack_i = '0;
        tick();
        tick();
        tick();
        bus.ch_en = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        bus.ch_en = ALL;
        bus.per_avail = ALL;
        tick();
        tick();
        checks++;
        if ({bus.dma_req_o, bus.per_done, bus.dma_nd_o, bus.dma_rest_o, bus.per_err} !== {5{NONE}}) begin
            errors++;
            $display("FAIL reset_outputs: req=%h done=%h nd=%h rest=%h err=%h want all 0",
                     bus.dma_req_o, bus.per_done, bus.dma_nd_o, bus.dma_rest_o, bus.per_err);
        end
        zero_inputs();
        rst_i = 1'b0;
        tick();
        checks++;
        if (bus.state_dbg !== '0 || bus.dma_req_o !== NONE) begin
            errors++;
            $display("FAIL reset_state: state=%h req=%h want 0", bus.state_dbg, bus.dma_req_o);
        end
    endtask

    task automatic test_basic();
        bus.ch_en[0] = 1'b1;
        bus.per_avail[0] = 1'b1;
        tick();
        checks++;
        if (bus.dma_req_o !== bitv(0)) begin
            errors++; $display("FAIL basic_req_rise: got %h want %h", bus.dma_req_o, bitv(0));
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (bus.dma_req_o !== bitv(0) || bus.per_done !== NONE) begin
                errors++; $display("FAIL basic_req_hold: cyc %0d req=%h done=%h", k, bus.dma_req_o, bus.per_done);
            end
        end
        bus.dma_ack_i[0] = 1'b1;
        tick();
        bus.dma_ack_i[0] = 1'b0;
        checks++;
        if (bus.per_done !== bitv(0) || bus.dma_req_o !== NONE || bus.dma_nd_o !== NONE || bus.dma_rest_o !== NONE) begin
            errors++; $display("FAIL basic_done: done=%h req=%h nd=%h rest=%h want done=1 others 0",
                               bus.per_done, bus.dma_req_o, bus.dma_nd_o, bus.dma_rest_o);
        end
        tick();
        checks++;
        if (bus.per_done !== NONE || bus.dma_req_o !== NONE) begin
            errors++; $display("FAIL basic_gap2: done=%h req=%h want 0", bus.per_done, bus.dma_req_o);
        end
        tick();
        checks++;
        if (bus.dma_req_o !== bitv(0)) begin
            errors++; $display("FAIL basic_rereq: got %h want %h", bus.dma_req_o, bitv(0));
        end
        drain();
    endtask

    task automatic test_eop();
        bus.ch_en[3] = 1'b1;
        bus.per_avail[3] = 1'b1;
        bus.per_eop[3] = 1'b1;
        tick();
        bus.per_avail[3] = 1'b0;
        bus.per_eop[3] = 1'b0;
        checks++;
        if (bus.dma_req_o !== bitv(3)) begin
            errors++; $display("FAIL eop_req: got %h want %h", bus.dma_req_o, bitv(3));
        end
        tick();
        bus.dma_ack_i[3] = 1'b1;
        tick();
        bus.dma_ack_i[3] = 1'b0;
        checks++;
        if (bus.per_done !== bitv(3) || bus.dma_nd_o !== bitv(3)) begin
            errors++; $display("FAIL eop_nd_done: done=%h nd=%h want %h", bus.per_done, bus.dma_nd_o, bitv(3));
        end
        tick();
        checks++;
        if (bus.per_done !== NONE || bus.dma_nd_o !== NONE) begin
            errors++; $display("FAIL eop_single: done=%h nd=%h want 0", bus.per_done, bus.dma_nd_o);
        end
        drain();
    endtask

    task automatic test_timeout();
        bus.ch_en[1] = 1'b1;
        bus.per_avail[1] = 1'b1;
        tick();
        bus.per_avail[1] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (bus.dma_req_o !== bitv(1) || bus.dma_rest_o !== NONE) begin
                errors++; $display("FAIL tmo_wait: cyc %0d req=%h rest=%h", k, bus.dma_req_o, bus.dma_rest_o);
            end
            tick();
        end
        checks++;
        if (bus.dma_req_o !== bitv(1)) begin
            errors++; $display("FAIL tmo_req8: got %h want %h", bus.dma_req_o, bitv(1));
        end
        tick();
        checks++;
        if (bus.dma_rest_o !== bitv(1) || bus.per_err !== bitv(1) || bus.dma_req_o !== NONE) begin
            errors++; $display("FAIL tmo_fire: rest=%h err=%h req=%h", bus.dma_rest_o, bus.per_err, bus.dma_req_o);
        end
        tick();
        checks++;
        if (bus.dma_rest_o !== NONE || bus.per_err !== bitv(1)) begin
            errors++; $display("FAIL tmo_sticky: rest=%h err=%h", bus.dma_rest_o, bus.per_err);
        end
        tick();
        tick();
        bus.err_clr[1] = 1'b1;
        tick();
        bus.err_clr[1] = 1'b0;
        checks++;
        if (bus.per_err !== NONE) begin
            errors++; $display("FAIL tmo_clr: err=%h want 0", bus.per_err);
        end
        // Second timeout, with err_clr landing on the timeout cycle.
        bus.per_avail[1] = 1'b1;
        tick();
        bus.per_avail[1] = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        bus.err_clr[1] = 1'b1;
        tick();
        bus.err_clr[1] = 1'b0;
        checks++;
        if (bus.dma_rest_o !== bitv(1) || bus.per_err !== bitv(1)) begin
            errors++; $display("FAIL tmo_set_wins: rest=%h err=%h want %h", bus.dma_rest_o, bus.per_err, bitv(1));
        end
        bus.err_clr[1] = 1'b1;
        tick();
        bus.err_clr[1] = 1'b0;
        checks++;
        if (bus.per_err !== NONE) begin
            errors++; $display("FAIL tmo_clr2: err=%h want 0", bus.per_err);
        end
        drain();
    endtask

    task automatic test_abort();
        // An abort in IDLE blocks the request and produces no rest pulse.
        bus.ch_en[2] = 1'b1;
        bus.per_avail[2] = 1'b1;
        bus.per_abort[2] = 1'b1;
        tick();
        bus.per_abort[2] = 1'b0;
        checks++;
        if (bus.dma_req_o !== NONE || bus.dma_rest_o !== NONE) begin
            errors++; $display("FAIL abort_idle: req=%h rest=%h want 0", bus.dma_req_o, bus.dma_rest_o);
        end
        tick();
        bus.per_avail[2] = 1'b0;
        checks++;
        if (bus.dma_req_o !== bitv(2)) begin
            errors++; $display("FAIL abort_req: got %h want %h", bus.dma_req_o, bitv(2));
        end
        bus.per_abort[2] = 1'b1;
        tick();
        bus.per_abort[2] = 1'b0;
        checks++;
        if (bus.dma_rest_o !== bitv(2) || bus.per_done !== NONE || bus.dma_req_o !== NONE) begin
            errors++; $display("FAIL abort_rest: rest=%h done=%h req=%h", bus.dma_rest_o, bus.per_done, bus.dma_req_o);
        end
        tick();
        checks++;
        if (bus.dma_rest_o !== NONE) begin
            errors++; $display("FAIL abort_pulse: rest=%h want 0", bus.dma_rest_o);
        end
        drain();
        // Ack and abort together on a channel with eop latched.
        bus.ch_en[4] = 1'b1;
        bus.per_avail[4] = 1'b1;
        bus.per_eop[4] = 1'b1;
        tick();
        bus.per_avail[4] = 1'b0;
        bus.per_eop[4] = 1'b0;
        bus.dma_ack_i[4] = 1'b1;
        bus.per_abort[4] = 1'b1;
        tick();
        bus.dma_ack_i[4] = 1'b0;
        bus.per_abort[4] = 1'b0;
        checks++;
        if (bus.per_done !== bitv(4) || bus.dma_rest_o !== bitv(4) || bus.dma_nd_o !== NONE) begin
            errors++; $display("FAIL ack_abort: done=%h rest=%h nd=%h want done=rest=%h nd=0",
                               bus.per_done, bus.dma_rest_o, bus.dma_nd_o, bitv(4));
        end
        drain();
    endtask

    task automatic test_ack_timeout();
        bus.ch_en[5] = 1'b1;
        bus.per_avail[5] = 1'b1;
        tick();
        bus.per_avail[5] = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        bus.dma_ack_i[5] = 1'b1;
        tick();
        bus.dma_ack_i[5] = 1'b0;
        checks++;
        if (bus.per_done !== bitv(5) || bus.dma_rest_o !== NONE || bus.per_err !== NONE) begin
            errors++; $display("FAIL ack_tmo: done=%h rest=%h err=%h want done=%h",
                               bus.per_done, bus.dma_rest_o, bus.per_err, bitv(5));
        end
        drain();
    endtask

    task automatic test_en_drop();
        bus.ch_en[6] = 1'b1;
        bus.per_avail[6] = 1'b1;
        tick();
        bus.per_avail[6] = 1'b0;
        bus.ch_en[6] = 1'b0;
        tick();
        checks++;
        if (bus.dma_rest_o !== bitv(6) || bus.per_done !== NONE || bus.dma_req_o !== NONE) begin
            errors++; $display("FAIL en_drop: rest=%h done=%h req=%h", bus.dma_rest_o, bus.per_done, bus.dma_req_o);
        end
        drain();
    endtask

    task automatic test_rst_mid();
        bus.ch_en[7] = 1'b1;
        bus.per_avail[7] = 1'b1;
        tick();
        checks++;
        if (bus.dma_req_o !== bitv(7)) begin
            errors++; $display("FAIL rstmid_req: got %h want %h", bus.dma_req_o, bitv(7));
        end
        rst_i = 1'b1;
        tick();
        checks++;
        if ({bus.dma_req_o, bus.per_done, bus.dma_nd_o, bus.dma_rest_o, bus.per_err} !== {5{NONE}}) begin
            errors++; $display("FAIL rstmid_out: req=%h done=%h nd=%h rest=%h err=%h want 0",
                               bus.dma_req_o, bus.per_done, bus.dma_nd_o, bus.dma_rest_o, bus.per_err);
        end
        rst_i = 1'b0;
        zero_inputs();
        tick();
    endtask

    task automatic test_all_channels();
        logic [N-1:0] eop_pat;
        logic [N-1:0] pending;
        logic [N-1:0] exp;
        logic [N-1:0] m;
        eop_pat = 31'h5A5A_1234;
        // Channel i is acked (i % 6) + 1 cycles after its request rises.
        for (int t = 1; t <= 8; t++) begin
            m = '0;
            for (int i = 0; i < N; i++) if ((i % 6) + 1 == t) m[i] = 1'b1;
            exp_q.push_back(m);
        end
        bus.ch_en = ALL;
        bus.per_avail = ALL;
        bus.per_eop = eop_pat;
        tick();
        bus.per_avail = '0;
        bus.per_eop = '0;
        checks++;
        if (bus.dma_req_o !== ALL) begin
            errors++; $display("FAIL all_req: got %h want %h", bus.dma_req_o, ALL);
        end
        pending = ALL;
        for (int t = 1; t <= 8; t++) begin
            exp = exp_q.pop_front();
            bus.dma_ack_i = exp;
            tick();
            bus.dma_ack_i = '0;
            pending = pending & ~exp;
            checks++;
            if (bus.per_done !== exp || bus.dma_nd_o !== (exp & eop_pat) || bus.dma_rest_o !== NONE) begin
                errors++; $display("FAIL all_done t=%0d: done=%h nd=%h rest=%h want done=%h nd=%h",
                                   t, bus.per_done, bus.dma_nd_o, bus.dma_rest_o, exp, exp & eop_pat);
            end
            checks++;
            if (bus.dma_req_o !== pending) begin
                errors++; $display("FAIL all_req t=%0d: got %h want %h", t, bus.dma_req_o, pending);
            end
        end
        drain();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_i = 1'b1;
        zero_inputs();
        @(negedge clk);
        test_reset();
        test_basic();
        test_eop();
        test_timeout();
        test_abort();
        test_ack_timeout();
        test_en_drop();
        test_rst_mid();
        test_all_channels();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
